ma_access_unit: RTL and testbench

Memory-access (MA) stage controller that consumes the EX/MA pipeline-register outputs and drives a word-wide request/acknowledge data-memory port. It stalls upstream while a load or store is outstanding and captures load data. It also contains the MA/WB pipeline register, so writeback sees registered results. Non-memory instructions pass through with one cycle of latency.

---
 rtl/ma_access_unit_pkg.sv | 10 +
 rtl/ma_access_unit_if.sv | 11 +
 rtl/ma_wb_buffer.sv | 31 +++
 rtl/ma_access_unit.sv | 89 ++++++++
 tb/tb_ma_access_unit.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/ma_access_unit_pkg.sv
// ma_access_unit_pkg: shared state encoding, default width and writeback bubble constant
package ma_access_unit_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_ACK = 2'd2, DONE = 2'd3} state_t;
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;
  localparam wb_ctrl_t WB_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0};
endpackage

// File: rtl/ma_access_unit_if.sv
// ma_access_unit_if: word-wide request/acknowledge data-memory port
interface ma_access_unit_if import ma_access_unit_pkg::*; #(parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH);
  logic req;
  logic we;
  logic ack;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  modport master(output req, we, addr, wdata, input ack, rdata);
  modport slave(input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ma_wb_buffer.sv
// ma_wb_buffer: MA/WB pipeline register; bubble clears the writeback control bits
module ma_wb_buffer import ma_access_unit_pkg::*; #(parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pc_plus_4,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [4:0]            rd_addr,
  input  wb_ctrl_t              ctrl,
  input  logic                  bubble,
  output logic [DATA_WIDTH-1:0] wb_pc_plus_4,
  output logic [DATA_WIDTH-1:0] wb_alu_result,
  output logic [DATA_WIDTH-1:0] wb_mem_data,
  output logic [4:0]            wb_rd_addr,
  output wb_ctrl_t              wb_ctrl
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb_pc_plus_4  <= '0;
      wb_alu_result <= '0;
      wb_mem_data   <= '0;
      wb_rd_addr    <= '0;
      wb_ctrl       <= WB_BUBBLE;
    end else begin
      wb_pc_plus_4  <= pc_plus_4;
      wb_alu_result <= alu_result;
      wb_mem_data   <= mem_data;
      wb_rd_addr    <= rd_addr;
      wb_ctrl       <= bubble ? WB_BUBBLE : ctrl;
    end
endmodule

// File: rtl/ma_access_unit.sv
// ma_access_unit: MA stage controller; issues data-memory requests, stalls upstream, owns MA/WB register
module ma_access_unit import ma_access_unit_pkg::*; #(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ma_pc_plus_4_in,
  input  logic [DATA_WIDTH-1:0] ma_alu_result_in,
  input  logic [DATA_WIDTH-1:0] ma_write_data_in,
  input  logic [4:0]            ma_rd_addr_in,
  input  logic                  ma_mem_read_in,
  input  logic                  ma_mem_write_in,
  input  logic                  ma_reg_write_in,
  input  logic                  ma_mem_to_reg_in,
  ma_access_unit_if.master      dmem,
  output logic                  stall_out,
  output logic [DATA_WIDTH-1:0] wb_pc_plus_4_out,
  output logic [DATA_WIDTH-1:0] wb_alu_result_out,
  output logic [DATA_WIDTH-1:0] wb_mem_data_out,
  output logic [4:0]            wb_rd_addr_out,
  output logic                  wb_reg_write_out,
  output logic                  wb_mem_to_reg_out,
  output logic                  err_misaligned,
  output logic                  err_timeout
);
  state_t state, next_state;
  logic [7:0] cnt;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q;
  logic we_q, mem_op, misaligned, start, in_access, ack, timeout, pass;
  wb_ctrl_t wb_ctrl;
  assign mem_op     = ma_mem_read_in | ma_mem_write_in;
  assign misaligned = ma_alu_result_in[1:0] != 2'b00;
  assign start      = state == IDLE && mem_op && !misaligned;
  assign in_access  = state == REQ || state == WAIT_ACK;
  assign ack        = in_access && dmem.ack;
  // ack in the final wait cycle takes priority over the timeout
  assign timeout    = state == WAIT_ACK && !dmem.ack && cnt + 8'd1 == 8'(TIMEOUT_CYCLES);
  assign pass       = (state == IDLE && !mem_op) || ack;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  always_comb
    next_state = state == IDLE ? (start ? REQ : IDLE) :
                 state == DONE ? IDLE :
                 (ack || timeout) ? DONE : WAIT_ACK;
  always_comb begin
    stall_out = start || in_access;
    dmem.req  = in_access;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt            <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      we_q           <= 1'b0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      cnt            <= start ? 8'd0 : state == WAIT_ACK ? cnt + 8'd1 : cnt;
      err_misaligned <= state == IDLE && mem_op && misaligned;
      err_timeout    <= timeout;
      if (start) begin
        addr_q  <= {ma_alu_result_in[DATA_WIDTH-1:2], 2'b00};
        wdata_q <= ma_write_data_in;
        we_q    <= ma_mem_write_in;
      end
    end
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign dmem.we    = we_q;
  ma_wb_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_wb (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_plus_4    (ma_pc_plus_4_in),
    .alu_result   (ma_alu_result_in),
    .mem_data     ((ack && !we_q) ? dmem.rdata : '0),
    .rd_addr      (ma_rd_addr_in),
    .ctrl         ('{reg_write: ma_reg_write_in, mem_to_reg: ma_mem_to_reg_in}),
    .bubble       (!pass),
    .wb_pc_plus_4 (wb_pc_plus_4_out),
    .wb_alu_result(wb_alu_result_out),
    .wb_mem_data  (wb_mem_data_out),
    .wb_rd_addr   (wb_rd_addr_out),
    .wb_ctrl      (wb_ctrl)
  );
  assign wb_reg_write_out  = wb_ctrl.reg_write;
  assign wb_mem_to_reg_out = wb_ctrl.mem_to_reg;
endmodule

// File: tb/tb_ma_access_unit.sv
// tb_ma_access_unit: directed tests of the MA access unit with a 4-cycle timeout
module tb_ma_access_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] pc, alu, wd;
  logic [4:0] rd;
  logic mr, mw, rw, m2r;
  logic stall;
  logic [31:0] wb_pc, wb_alu, wb_md;
  logic [4:0] wb_rd;
  logic wb_rw, wb_m2r, e_mis, e_to;
  int errors = 0, checks = 0;
  int req_cycles = 0, req_starts = 0;
  logic req_d = 1'b0;
  ma_access_unit_if #(.DATA_WIDTH(32)) bus ();
  ma_access_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ma_pc_plus_4_in(pc), .ma_alu_result_in(alu), .ma_write_data_in(wd), .ma_rd_addr_in(rd),
    .ma_mem_read_in(mr), .ma_mem_write_in(mw), .ma_reg_write_in(rw), .ma_mem_to_reg_in(m2r),
    .dmem(bus.master), .stall_out(stall),
    .wb_pc_plus_4_out(wb_pc), .wb_alu_result_out(wb_alu), .wb_mem_data_out(wb_md),
    .wb_rd_addr_out(wb_rd), .wb_reg_write_out(wb_rw), .wb_mem_to_reg_out(wb_m2r),
    .err_misaligned(e_mis), .err_timeout(e_to)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.req) req_cycles++;
    if (bus.req && !req_d) req_starts++;
    req_d = bus.req;
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(input logic [31:0] p, a, w, input logic [4:0] r, input logic rdm, wrm, regw, mtr);
    pc = p; alu = a; wd = w; rd = r; mr = rdm; mw = wrm; rw = regw; m2r = mtr;
  endtask
  task automatic test_reset;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    bus.ack = 1'b0; bus.rdata = '0;
    step; step;
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if ({wb_pc, wb_alu, wb_md, wb_rd, wb_rw, wb_m2r, e_mis, e_to} !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", {wb_pc, wb_alu, wb_md, wb_rd, wb_rw, wb_m2r, e_mis, e_to}); end
    rst_n = 1'b1;
  endtask
  task automatic test_alu;
    set_in(32'h44, 32'h10, 32'h0, 5'd5, 0, 0, 1, 0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b want 0", stall); end
    step;
    checks++; if (wb_alu !== 32'h10) begin errors++; $display("FAIL alu_result: got %h want 10", wb_alu); end
    checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL alu_rd: got %0d want 5", wb_rd); end
    checks++; if (wb_rw !== 1'b1) begin errors++; $display("FAIL alu_reg_write: got %b want 1", wb_rw); end
    checks++; if (wb_pc !== 32'h44 || wb_md !== 32'h0) begin errors++; $display("FAIL alu_pc_md: got %h/%h want 44/0", wb_pc, wb_md); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step;
  endtask
  task automatic test_load;
    set_in(32'h104, 32'h100, 32'h0, 5'd7, 1, 0, 1, 1);
    #1;
    checks++; if (stall !== 1'b1 || bus.req !== 1'b0) begin errors++; $display("FAIL load_detect: stall/req got %b%b want 10", stall, bus.req); end
    step;
    bus.ack = 1'b1; bus.rdata = 32'hDEADBEEF;
    #1;
    checks++; if (bus.req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL load_req: req/stall got %b%b want 11", bus.req, stall); end
    checks++; if (bus.addr !== 32'h100 || bus.we !== 1'b0) begin errors++; $display("FAIL load_addr_we: got %h/%b want 100/0", bus.addr, bus.we); end
    step;
    bus.ack = 1'b0; bus.rdata = '0;
    checks++; if (wb_md !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data: got %h want deadbeef", wb_md); end
    checks++; if (wb_m2r !== 1'b1 || wb_rw !== 1'b1 || wb_rd !== 5'd7) begin errors++; $display("FAIL load_ctrl: m2r/rw/rd got %b/%b/%0d want 1/1/7", wb_m2r, wb_rw, wb_rd); end
    checks++; if (bus.req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL load_done: req/stall got %b%b want 00", bus.req, stall); end
    step;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (wb_rw !== 1'b0 || wb_md !== 32'h0) begin errors++; $display("FAIL load_bubble: rw/md got %b/%h want 0/0", wb_rw, wb_md); end
    step;
  endtask
  task automatic test_store;
    int c0, s0;
    c0 = req_cycles; s0 = req_starts;
    set_in(32'h208, 32'h204, 32'h1234, 5'd0, 0, 1, 0, 0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL store_detect: got %b want 1", stall); end
    step;
    for (int i = 0; i < 5; i++) begin
      bus.ack = (i == 4);
      #1;
      checks++; if (bus.req !== 1'b1 || bus.we !== 1'b1 || bus.wdata !== 32'h1234 || bus.addr !== 32'h204) begin errors++; $display("FAIL store_bus_%0d: req/we/wdata/addr got %b/%b/%h/%h", i, bus.req, bus.we, bus.wdata, bus.addr); end
      step;
    end
    bus.ack = 1'b0;
    checks++; if (bus.req !== 1'b0 || wb_rw !== 1'b0 || wb_md !== 32'h0) begin errors++; $display("FAIL store_done: req/rw/md got %b/%b/%h want 0/0/0", bus.req, wb_rw, wb_md); end
    checks++; if (e_to !== 1'b0) begin errors++; $display("FAIL store_no_timeout: got %b want 0", e_to); end
    step;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (req_cycles - c0 !== 5) begin errors++; $display("FAIL store_req_cycles: got %0d want 5", req_cycles - c0); end
    checks++; if (req_starts - s0 !== 1) begin errors++; $display("FAIL store_req_count: got %0d want 1", req_starts - s0); end
    step;
  endtask
  task automatic test_misaligned;
    int s0;
    s0 = req_starts;
    set_in(32'h30, 32'h102, 32'h0, 5'd9, 1, 0, 1, 1);
    #1;
    checks++; if (stall !== 1'b0 || bus.req !== 1'b0) begin errors++; $display("FAIL mis_stall: stall/req got %b%b want 00", stall, bus.req); end
    step;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (e_mis !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b want 1", e_mis); end
    checks++; if (wb_rw !== 1'b0 || wb_m2r !== 1'b0 || wb_alu !== 32'h102) begin errors++; $display("FAIL mis_bubble: rw/m2r/alu got %b/%b/%h want 0/0/102", wb_rw, wb_m2r, wb_alu); end
    step;
    checks++; if (e_mis !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %b want 0", e_mis); end
    checks++; if (req_starts !== s0) begin errors++; $display("FAIL mis_no_req: got %0d starts want 0", req_starts - s0); end
  endtask
  task automatic test_timeout;
    set_in(32'h304, 32'h300, 32'h0, 5'd4, 1, 0, 1, 1);
    step;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.req !== 1'b1 || e_to !== 1'b0) begin errors++; $display("FAIL to_wait_%0d: req/err got %b%b want 10", i, bus.req, e_to); end
      step;
    end
    checks++; if (e_to !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", e_to); end
    checks++; if (bus.req !== 1'b0 || stall !== 1'b0 || wb_rw !== 1'b0) begin errors++; $display("FAIL to_done: req/stall/rw got %b%b%b want 000", bus.req, stall, wb_rw); end
    bus.ack = 1'b1; bus.rdata = 32'hBAD0BAD0;
    step;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (e_to !== 1'b0 || wb_md !== 32'h0 || bus.req !== 1'b0) begin errors++; $display("FAIL to_late_ack: err/md/req got %b/%h/%b want 0/0/0", e_to, wb_md, bus.req); end
    step;
    checks++; if (bus.req !== 1'b0 || stall !== 1'b0 || wb_md !== 32'h0) begin errors++; $display("FAIL to_idle_ack: req/stall/md got %b%b/%h want 00/0", bus.req, stall, wb_md); end
    bus.ack = 1'b0; bus.rdata = '0;
  endtask
  task automatic test_reset_mid;
    set_in(32'h404, 32'h400, 32'h0, 5'd6, 1, 0, 1, 1);
    step; step;
    checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b want 1", bus.req); end
    #2;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    bus.ack = 1'b1; bus.rdata = 32'h5A5A5A5A;
    #1;
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL rst_async_req: got %b want 0", bus.req); end
    checks++; if ({stall, wb_pc, wb_alu, wb_md, wb_rd, wb_rw, wb_m2r, e_mis, e_to, bus.addr, bus.wdata, bus.we} !== '0) begin errors++; $display("FAIL rst_outputs: got %h want 0", {stall, wb_pc, wb_alu, wb_md, wb_rd, wb_rw, wb_m2r, e_mis, e_to, bus.addr, bus.wdata, bus.we}); end
    step;
    rst_n = 1'b1;
    step;
    checks++; if (bus.req !== 1'b0 || wb_md !== 32'h0) begin errors++; $display("FAIL rst_late_ack: req/md got %b/%h want 0/0", bus.req, wb_md); end
    bus.ack = 1'b0;
    set_in(32'h560, 32'h55C, 32'h0, 5'd3, 0, 0, 1, 0);
    step;
    checks++; if (wb_alu !== 32'h55C || wb_rd !== 5'd3 || wb_rw !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL rst_after_alu: alu/rd/rw/stall got %h/%0d/%b/%b", wb_alu, wb_rd, wb_rw, stall); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_alu;
    test_load;
    test_store;
    test_misaligned;
    test_timeout;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
